frame_buffer_write_ctrl: RTL and testbench
==========================================

Name: frame_buffer_write_ctrl

Overview:
- Sequences the write port of the frame-buffer RAM from the camera capture pixel stream.
- Synchronises to frame start (vsync rising edge) and generates linear write addresses 0..DEPTH-1 with data and write enable.
- Signals frame completion and flags short or over-long frames.
- Sits between the camera capture block and the RAM write side; everything runs in the camera pixel clock domain.

Parameters:
- WIDTH, 12, pixel width in bits (RGB444).
- DEPTH, 76800, pixels per frame (320x240); also the RAM depth.
- ADDR_W, $clog2(DEPTH) (17 at default), address width; derived, not overridden.

Ports:
- clk_i  input  1  pixel clock; single clock for the whole block.
- reset_i  input  1  synchronous, active-high reset.
- enable_i  input  1  capture enable; deassertion aborts capture.
- continuous_i  input  1  1 = re-arm after each frame; 0 = single shot.
- vsync_i  input  1  camera vsync; a rising edge marks frame start.
- pixel_valid_i  input  1  pixel_data_i is valid this cycle.
- pixel_data_i  input  WIDTH  pixel value.
- clear_flags_i  input  1  clears the sticky error flags.
- wr_en_o  output  1  RAM write enable.
- wr_address_o  output  ADDR_W  RAM write address.
- wr_data_o  output  WIDTH  RAM write data.
- busy_o  output  1  high in WAIT_VSYNC or CAPTURE.
- frame_done_o  output  1  one-cycle pulse when a full frame has been written.
- frame_count_o  output  16  completed-frame counter; wraps at 16'hFFFF -> 0.
- short_frame_o  output  1  sticky: vsync edge arrived before DEPTH pixels.
- overflow_o  output  1  sticky: pixel_valid_i seen between frame completion and the next vsync edge.

Behaviour:
- Reset (synchronous)
  - All outputs go to 0; state = IDLE; pixel counter = 0.
  - The vsync history register resets to 1, so vsync_i held high at reset release is not an edge.
- Edge detect: vs_edge = vsync_i & ~vsync_q, with vsync_q registered every cycle.
- Write-side outputs are registered with 1-cycle latency: a pixel accepted in cycle n appears as wr_en_o=1 with its address and data in cycle n+1.
- wr_en_o is 0 in every cycle that has no accepted pixel.
- States: IDLE, WAIT_VSYNC, CAPTURE, DONE.
- IDLE
  - Pixels are ignored.
  - enable_i=1 -> WAIT_VSYNC.
- WAIT_VSYNC
  - Pixels are ignored.
  - If pixel_valid_i=1 and a frame has completed since the last arm (had_frame flag), set overflow_o.
  - vs_edge -> CAPTURE with counter = 0.
- CAPTURE
  - Each pixel_valid_i=1 accepts the pixel at address = counter, then counter++.
  - Accepting the pixel at counter = DEPTH-1 -> DONE.
  - vs_edge with counter < DEPTH: set short_frame_o, counter = 0, stay in CAPTURE. No frame_done_o pulse.
  - vs_edge and pixel_valid_i in the same cycle: vsync wins and that pixel is discarded (not written).
- DONE (exactly one cycle)
  - frame_done_o=1 and frame_count_o increments; had_frame is set.
  - Next state: WAIT_VSYNC if continuous_i=1 and enable_i=1, else IDLE.
  - The last pixel's write (wr_en_o) lands in this same cycle.
- enable_i=0 in any state other than IDLE
  - Next state = IDLE and counter = 0. No frame_done_o pulse.
  - A pixel accepted in the previous cycle still completes its registered write.
- Arming from IDLE clears had_frame.
- Address never exceeds DEPTH-1; there is no wrap inside a frame.
- clear_flags_i clears short_frame_o and overflow_o. If a set condition occurs in the same cycle, set wins.
- busy_o is combinational from state.

Decomposition:
- Package fb_pkg
  - FB_WIDTH=12, FB_DEPTH=76800, FB_ADDR_W.
  - Typedef wr_state_t enum {IDLE, WAIT_VSYNC, CAPTURE, DONE}.
  - Typedef pixel_t logic [FB_WIDTH-1:0].
- One sub-module, rising_edge_detect: registered history with a parameterised reset value; it produces vs_edge.
- The FSM, counter and flags stay in the top module.

Test Plan:
(Run with DEPTH=16.)
- Basic frame: reset, enable_i=1, continuous_i=0, vsync pulse, then 16 consecutive valid pixels with data = 12'h100+i.
  - wr_en_o high for 16 cycles, addresses 0..15 (each 1 cycle after its pixel), data 12'h100..12'h10F.
  - frame_done_o pulses once; frame_count_o=1; state returns to IDLE; busy_o=0.
- Pre-sync pixels: pixels driven before the first vsync edge and while in IDLE -> no wr_en_o; overflow_o stays 0.
- Short frame: vsync, 10 pixels, vsync, 16 pixels.
  - short_frame_o=1 after the second edge; the second frame writes addresses 0..15.
  - Exactly one frame_done_o; frame_count_o=1.
- Continuous mode with extras: continuous_i=1, two frames, 3 extra pixels between DONE and the next vsync.
  - overflow_o=1; extras not written; frame_count_o=2.
  - clear_flags_i pulse -> overflow_o=0.
- Abort: enable_i dropped after 7 pixels.
  - Next cycle state=IDLE, busy_o=0; no frame_done_o.
  - Re-enable, vsync, 16 pixels -> addresses restart at 0.
- Simultaneous events and reset
  - vs_edge coincident with pixel_valid_i in CAPTURE -> that pixel is not written; counter restarts at 0.
  - reset_i asserted mid-frame -> all outputs 0 the next cycle.
  - vsync_i held high through reset release -> no capture starts until a fresh rising edge.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer write sequencer.
package fb_pkg;

    localparam int FB_WIDTH  = 12;
    localparam int FB_DEPTH  = 76800;
    localparam int FB_ADDR_W = $clog2(FB_DEPTH);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_VSYNC = 2'd1,
        CAPTURE    = 2'd2,
        DONE       = 2'd3
    } wr_state_t;

    typedef logic [FB_WIDTH-1:0] pixel_t;

endpackage

// File: rtl/frame_buffer_write_ctrl_rising_edge_detect.sv
// Rising-edge detector with a configurable history reset value, so a level
// already high when reset releases is not mistaken for an edge.
module rising_edge_detect
    import fb_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sig_i,
    output logic edge_o
);

    logic r_sig_q;

    // History register for the edge comparison
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_sig_q <= RESET_VAL;
        end else begin
            r_sig_q <= sig_i;
        end
    end

    assign edge_o = sig_i & ~r_sig_q;

endmodule

// File: rtl/frame_buffer_write_ctrl.sv
// Drives the frame-buffer RAM write port from the camera pixel stream:
// vsync-aligned linear addressing, frame-done pulse and sticky error flags.
module frame_buffer_write_ctrl
    import fb_pkg::*;
#(
    parameter  int WIDTH  = FB_WIDTH,
    parameter  int DEPTH  = FB_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic              continuous_i,
    input  logic              vsync_i,
    input  logic              pixel_valid_i,
    input  logic [WIDTH-1:0]  pixel_data_i,
    input  logic              clear_flags_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_address_o,
    output logic [WIDTH-1:0]  wr_data_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [15:0]       frame_count_o,
    output logic              short_frame_o,
    output logic              overflow_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    wr_state_t         r_state;
    wr_state_t         w_next_state;
    logic              w_vs_edge;
    logic              w_busy;
    logic              w_accept;
    logic              w_frame_end;
    logic              w_arm;
    logic              w_set_short;
    logic              w_set_over;
    logic [ADDR_W-1:0] r_count;
    logic              r_had_frame;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [WIDTH-1:0]  r_wr_data;
    logic              r_frame_done;
    logic [15:0]       r_frame_count;
    logic              r_short;
    logic              r_overflow;

    rising_edge_detect #(
        .RESET_VAL(1'b1)
    ) u_vsync_edge (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .sig_i  (vsync_i),
        .edge_o (w_vs_edge)
    );

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; dropping enable aborts from any state
    always_comb begin
        w_next_state = r_state;
        if (!enable_i) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:       w_next_state = WAIT_VSYNC;
                WAIT_VSYNC: w_next_state = w_vs_edge ? CAPTURE : WAIT_VSYNC;
                CAPTURE:    w_next_state = w_frame_end ? DONE : CAPTURE;
                DONE:       w_next_state = continuous_i ? WAIT_VSYNC : IDLE;
                default:    w_next_state = IDLE;
            endcase
        end
    end

    // FSM decoded controls; a vsync edge in CAPTURE discards the coincident pixel
    always_comb begin
        w_busy      = 1'b0;
        w_accept    = 1'b0;
        w_arm       = 1'b0;
        w_set_short = 1'b0;
        w_set_over  = 1'b0;
        case (r_state)
            IDLE: begin
                w_arm = enable_i;
            end
            WAIT_VSYNC: begin
                w_busy     = 1'b1;
                w_set_over = enable_i & pixel_valid_i & r_had_frame;
            end
            CAPTURE: begin
                w_busy      = 1'b1;
                w_set_short = enable_i & w_vs_edge;
                w_accept    = enable_i & ~w_vs_edge & pixel_valid_i;
            end
            DONE: begin
                w_busy = 1'b0;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
        w_frame_end = w_accept & (r_count == LAST_ADDR);
    end

    // Pixel counter: restarts on frame end, vsync, abort or outside CAPTURE
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (w_accept && !w_frame_end) begin
            r_count <= r_count + ADDR_W'(1'b1);
        end else if (w_accept || (r_state != CAPTURE) || w_vs_edge || !enable_i) begin
            r_count <= '0;
        end else begin
            r_count <= r_count;
        end
    end

    // Registered write port, frame bookkeeping and sticky flags (set beats clear)
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_frame_done  <= 1'b0;
            r_frame_count <= 16'd0;
            r_had_frame   <= 1'b0;
            r_short       <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_wr_en      <= w_accept;
            r_frame_done <= w_frame_end;
            if (w_accept) begin
                r_wr_addr <= r_count;
                r_wr_data <= pixel_data_i;
            end
            if (w_frame_end) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (w_frame_end) begin
                r_had_frame <= 1'b1;
            end else if (w_arm) begin
                r_had_frame <= 1'b0;
            end
            r_short    <= w_set_short | (r_short & ~clear_flags_i);
            r_overflow <= w_set_over | (r_overflow & ~clear_flags_i);
        end
    end

    assign wr_en_o       = r_wr_en;
    assign wr_address_o  = r_wr_addr;
    assign wr_data_o     = r_wr_data;
    assign busy_o        = w_busy;
    assign frame_done_o  = r_frame_done;
    assign frame_count_o = r_frame_count;
    assign short_frame_o = r_short;
    assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_frame_buffer_write_ctrl.sv
// Directed-plus-random bench for frame_buffer_write_ctrl (DEPTH=16) against a
// frame-level behavioural model of capture, completion and error flags.
module tb_frame_buffer_write_ctrl;

    localparam int WIDTH  = 12;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              reset_i;
    logic              enable_i;
    logic              continuous_i;
    logic              vsync_i;
    logic              pixel_valid_i;
    logic [WIDTH-1:0]  pixel_data_i;
    logic              clear_flags_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_address_o;
    logic [WIDTH-1:0]  wr_data_o;
    logic              busy_o;
    logic              frame_done_o;
    logic [15:0]       frame_count_o;
    logic              short_frame_o;
    logic              overflow_o;

    int errors = 0;
    int checks = 0;

    // Held stimulus levels
    bit s_rst, s_en, s_cont, s_vs, s_clr;

    // Behavioural model: armed / capturing / one-cycle completion
    bit m_prev, m_waiting, m_capturing, m_just_done, m_had, m_short, m_over, m_exp_wr;
    int m_n, m_frames;
    logic [ADDR_W-1:0] m_exp_addr;
    logic [WIDTH-1:0]  m_exp_data;

    always #5 clk = ~clk;

    frame_buffer_write_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .continuous_i (continuous_i),
        .vsync_i      (vsync_i),
        .pixel_valid_i(pixel_valid_i),
        .pixel_data_i (pixel_data_i),
        .clear_flags_i(clear_flags_i),
        .wr_en_o      (wr_en_o),
        .wr_address_o (wr_address_o),
        .wr_data_o    (wr_data_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .frame_count_o(frame_count_o),
        .short_frame_o(short_frame_o),
        .overflow_o   (overflow_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input bit pv, input logic [WIDTH-1:0] d);
        bit edge_s, set_s, set_o;
        m_exp_wr = 1'b0;
        set_s    = 1'b0;
        set_o    = 1'b0;
        if (s_rst) begin
            m_prev = 1'b1; m_waiting = 1'b0; m_capturing = 1'b0; m_just_done = 1'b0;
            m_had = 1'b0; m_short = 1'b0; m_over = 1'b0; m_n = 0; m_frames = 0;
            m_exp_addr = '0; m_exp_data = '0;
            return;
        end
        edge_s = s_vs & ~m_prev;
        m_prev = s_vs;
        if (m_just_done) begin
            m_just_done = 1'b0;
            m_waiting   = s_en & s_cont;
        end else if (!s_en) begin
            m_waiting   = 1'b0;
            m_capturing = 1'b0;
        end else if (!m_waiting && !m_capturing) begin
            m_waiting = 1'b1;
            m_had     = 1'b0;
        end else if (m_waiting) begin
            if (pv && m_had) set_o = 1'b1;
            if (edge_s) begin
                m_waiting   = 1'b0;
                m_capturing = 1'b1;
                m_n         = 0;
            end
        end else begin
            if (edge_s) begin
                set_s = 1'b1;
                m_n   = 0;
            end else if (pv) begin
                m_exp_wr   = 1'b1;
                m_exp_addr = ADDR_W'(m_n);
                m_exp_data = d;
                m_n++;
                if (m_n == DEPTH) begin
                    m_capturing = 1'b0;
                    m_just_done = 1'b1;
                    m_had       = 1'b1;
                    m_frames++;
                end
            end
        end
        m_short = set_s | (m_short & ~s_clr);
        m_over  = set_o | (m_over & ~s_clr);
    endtask

    task automatic step(input bit pv, input logic [WIDTH-1:0] d);
        reset_i       = s_rst;
        enable_i      = s_en;
        continuous_i  = s_cont;
        vsync_i       = s_vs;
        clear_flags_i = s_clr;
        pixel_valid_i = pv;
        pixel_data_i  = d;
        model_update(pv, d);
        @(negedge clk);
        chk("wr_en", 32'(wr_en_o), 32'(m_exp_wr));
        if (m_exp_wr) begin
            chk("wr_address", 32'(wr_address_o), 32'(m_exp_addr));
            chk("wr_data", 32'(wr_data_o), 32'(m_exp_data));
        end
        if (s_rst) begin
            chk("rst_address", 32'(wr_address_o), 32'd0);
            chk("rst_data", 32'(wr_data_o), 32'd0);
        end
        chk("busy", 32'(busy_o), 32'(m_waiting | m_capturing));
        chk("frame_done", 32'(frame_done_o), 32'(m_just_done));
        chk("frame_count", 32'(frame_count_o), 32'(m_frames % 65536));
        chk("short_frame", 32'(short_frame_o), 32'(m_short));
        chk("overflow", 32'(overflow_o), 32'(m_over));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, WIDTH'($urandom));
    endtask

    task automatic pixels(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) step(1'b0, WIDTH'($urandom));
            step(1'b1, WIDTH'($urandom));
        end
    endtask

    task automatic vpulse();
        s_vs = 1'b1;
        step(1'b0, WIDTH'($urandom));
        s_vs = 1'b0;
    endtask

    initial begin
        s_rst = 1'b1; s_en = 1'b0; s_cont = 1'b0; s_vs = 1'b1; s_clr = 1'b0;
        m_prev = 1'b1;
        idle(2);
        s_rst = 1'b0;
        s_vs  = 1'b0;
        idle(2);

        // Pixels while idle and before any vsync edge
        pixels(3, 1'b0);
        s_en = 1'b1;
        idle(1);
        pixels(4, 1'b0);

        // Basic single-shot frame with ramp data
        vpulse();
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(i) + 12'h100);
        idle(3);

        // Short frame followed by a full frame
        vpulse();
        pixels(10, 1'b1);
        vpulse();
        pixels(DEPTH, 1'b1);
        idle(2);
        s_clr = 1'b1; idle(1); s_clr = 1'b0;

        // Continuous mode with extra pixels between frames
        s_cont = 1'b1;
        idle(2);
        vpulse();
        pixels(DEPTH, 1'b0);
        pixels(3, 1'b0);
        vpulse();
        pixels(DEPTH, 1'b1);
        idle(2);
        s_clr = 1'b1; idle(1); s_clr = 1'b0;

        // Abort mid-frame, then re-arm
        vpulse();
        pixels(7, 1'b0);
        s_en = 1'b0;
        step(1'b1, WIDTH'($urandom));
        idle(1);
        s_en = 1'b1; s_cont = 1'b0;
        idle(2);
        vpulse();
        pixels(DEPTH, 1'b0);
        idle(2);

        // vsync edge coincident with a valid pixel
        vpulse();
        pixels(5, 1'b0);
        s_vs = 1'b1;
        step(1'b1, WIDTH'($urandom));
        s_vs = 1'b0;
        pixels(DEPTH, 1'b0);
        idle(2);

        // Reset mid-frame
        vpulse();
        pixels(4, 1'b0);
        s_rst = 1'b1; step(1'b1, WIDTH'($urandom)); s_rst = 1'b0;
        idle(2);

        // vsync held high through reset release
        s_vs = 1'b1;
        s_rst = 1'b1; idle(2); s_rst = 1'b0;
        idle(2);
        pixels(5, 1'b0);
        s_vs = 1'b0;
        idle(1);
        vpulse();
        pixels(DEPTH, 1'b0);
        idle(2);

        // Random mix of all controls
        for (int i = 0; i < 600; i++) begin
            s_en   = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 15) == 0) s_cont = ~s_cont;
            if ($urandom_range(0, 24) == 0) s_vs = ~s_vs;
            s_clr  = ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 3) != 0, WIDTH'($urandom));
        end
        s_clr = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
